// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the MEM stage and the data memory
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_byte_en;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_byte_en, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte_en, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-enabled word SRAM responder with wait states and range error
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  c_we;
  logic [3:0]            c_be;
  logic [31:0]           c_addr;
  logic [31:0]           c_wdata;
  logic                  c_hit;
  logic [ADDR_WIDTH-1:0] c_idx;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = bus.req_valid && (state == IDLE);

  // With no wait states the access commits on the accept edge, straight from the bus.
  always_comb begin
    c_we    = we_q;
    c_be    = be_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_we    = bus.req_we;
      c_be    = bus.req_byte_en;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end
  end

  assign c_hit  = (c_addr[31:ADDR_WIDTH+2] == '0);
  assign c_idx  = c_addr[ADDR_WIDTH+1:2];
  assign commit = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (count == 4'd1));

  // Control FSM: capture on accept, count down wait states, hold the response until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            be_q    <= bus.req_byte_en;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            count   <= 4'(WAIT_STATES);
            if (WAIT_STATES != 0) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        state       <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !c_hit;
        rsp_rdata_q <= (c_hit && !c_we) ? mem[c_idx] : '0;
      end
    end
  end

  // Storage array: enabled byte lanes of an in-range store; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && c_we && c_hit && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule
